// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor width, FSM state encoding and the
// floor-to-LED helper used by the move controller and the display block.
package elevator_pkg;

  localparam int FLOOR_W = 5;
  localparam logic [FLOOR_W-1:0] FLOOR_MIN = 5'd1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GO_PICKUP   = 3'd1,
    DOOR_PICKUP = 3'd2,
    GO_DEST     = 3'd3,
    DOOR_DEST   = 3'd4
  } state_e;

  // Floor 0 is not a real floor and maps to all LEDs off.
  function automatic logic [30:0] floor_to_onehot(input logic [FLOOR_W-1:0] floor);
    logic [30:0] oh;
    oh = 31'd0;
    if (floor != 5'd0) begin
      oh[floor - 5'd1] = 1'b1;
    end else begin
      oh = 31'd0;
    end
    return oh;
  endfunction

endpackage

// File: rtl/elevator_tick_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module elevator_tick_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count_r;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == '0);

endmodule

// File: rtl/elevator_move_controller.sv
// Car movement FSM: pickup trip, door stop, destination trip, door stop.
// Build option ELEVATOR_REQUEST_QUEUE_EN adds a one-deep pending request slot.
module elevator_move_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = 9,
  parameter int TICKS_PER_FLOOR = 50000000,
  parameter int DOOR_TICKS      = 100000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    current,
  input  logic [FLOOR_W-1:0]    destination,
  input  logic                  input_confirm,
  output logic [FLOOR_W-1:0]    car_floor,
  output logic [NUM_FLOORS-1:0] floor_leds,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic                  busy,
  output logic                  done,
  output logic                  req_dropped
);

  localparam int MAX_TICKS = (TICKS_PER_FLOOR > DOOR_TICKS) ? TICKS_PER_FLOOR : DOOR_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TICKS_PER_FLOOR - 1);
  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS);

  state_e                  state_r, state_n;
  logic [FLOOR_W-1:0]      car_n, src_r, src_n, dst_r, dst_n;
  logic [FLOOR_W-1:0]      target_s, step_s, launch_src_s, launch_dst_s;
  logic [NUM_FLOORS-1:0]   leds_n;
  logic                    confirm_d_r, edge_s, valid_s, busy_eff_s, launch_s;
  logic                    load_s, tc_s, done_n, drop_n, up_n, down_n;
  logic [CNT_W-1:0]        load_val_s;
`ifdef ELEVATOR_REQUEST_QUEUE_EN
  logic                    pend_valid_r, pend_valid_n;
  logic [FLOOR_W-1:0]      pend_src_r, pend_src_n, pend_dst_r, pend_dst_n;
`endif

  elevator_tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (load_val_s),
    .tc       (tc_s)
  );

  assign edge_s  = input_confirm & ~confirm_d_r;
  assign valid_s = (current >= FLOOR_MIN) && (current <= TOP_FLOOR) &&
                   (destination >= FLOOR_MIN) && (destination <= TOP_FLOOR);
  // The done cycle still counts as busy so a coincident edge is not launched.
`ifdef ELEVATOR_REQUEST_QUEUE_EN
  assign busy_eff_s = (state_r != IDLE) || done || pend_valid_r;
`else
  assign busy_eff_s = (state_r != IDLE) || done;
`endif

  // Next-state, travel stepping, request acceptance and output decode.
  always_comb begin
    state_n      = state_r;
    car_n        = car_floor;
    src_n        = src_r;
    dst_n        = dst_r;
    load_s       = 1'b0;
    load_val_s   = TRAVEL_LOAD;
    done_n       = 1'b0;
    drop_n       = 1'b0;
    launch_s     = 1'b0;
    launch_src_s = current;
    launch_dst_s = destination;
    target_s     = (state_r == GO_PICKUP) ? src_r : dst_r;
    step_s       = (target_s > car_floor) ? car_floor + 5'd1 : car_floor - 5'd1;
`ifdef ELEVATOR_REQUEST_QUEUE_EN
    pend_valid_n = pend_valid_r;
    pend_src_n   = pend_src_r;
    pend_dst_n   = pend_dst_r;
`endif
    case (state_r)
      IDLE: begin
`ifdef ELEVATOR_REQUEST_QUEUE_EN
        if (pend_valid_r) begin
          launch_s     = 1'b1;
          launch_src_s = pend_src_r;
          launch_dst_s = pend_dst_r;
          pend_valid_n = 1'b0;
        end else begin
          launch_s = edge_s && valid_s && !done;
        end
`else
        launch_s = edge_s && valid_s && !done;
`endif
      end
      GO_PICKUP, GO_DEST: begin
        if (tc_s) begin
          car_n  = step_s;
          load_s = 1'b1;
          if (step_s == target_s) begin
            state_n    = (state_r == GO_PICKUP) ? DOOR_PICKUP : DOOR_DEST;
            load_val_s = DOOR_LOAD;
          end else begin
            load_val_s = TRAVEL_LOAD;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      DOOR_PICKUP: begin
        if (tc_s && (dst_r == car_floor)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (tc_s) begin
          state_n = GO_DEST;
          load_s  = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      DOOR_DEST: begin
        if (tc_s) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          done_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (launch_s) begin
      src_n  = launch_src_s;
      dst_n  = launch_dst_s;
      load_s = 1'b1;
      if (launch_src_s != car_floor) begin
        state_n    = GO_PICKUP;
        load_val_s = TRAVEL_LOAD;
      end else begin
        state_n    = DOOR_PICKUP;
        load_val_s = DOOR_LOAD;
      end
    end else begin
      src_n = src_n;
    end

    if (edge_s && !valid_s) begin
      drop_n = 1'b1;
    end else if (edge_s && busy_eff_s) begin
`ifdef ELEVATOR_REQUEST_QUEUE_EN
      if (!pend_valid_r) begin
        pend_valid_n = 1'b1;
        pend_src_n   = current;
        pend_dst_n   = destination;
      end else begin
        drop_n = 1'b1;
      end
`else
      drop_n = 1'b1;
`endif
    end else begin
      drop_n = drop_n;
    end

    up_n   = ((state_n == GO_PICKUP) && (src_n > car_n)) || ((state_n == GO_DEST) && (dst_n > car_n));
    down_n = ((state_n == GO_PICKUP) && (src_n < car_n)) || ((state_n == GO_DEST) && (dst_n < car_n));
    leds_n = NUM_FLOORS'(floor_to_onehot(car_n));
  end

  // State, request and registered output update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      confirm_d_r  <= 1'b0;
      src_r        <= FLOOR_MIN;
      dst_r        <= FLOOR_MIN;
      car_floor    <= FLOOR_MIN;
      floor_leds   <= NUM_FLOORS'(1);
      moving_up    <= 1'b0;
      moving_down  <= 1'b0;
      door_open    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      req_dropped  <= 1'b0;
`ifdef ELEVATOR_REQUEST_QUEUE_EN
      pend_valid_r <= 1'b0;
      pend_src_r   <= FLOOR_MIN;
      pend_dst_r   <= FLOOR_MIN;
`endif
    end else begin
      state_r      <= state_n;
      confirm_d_r  <= input_confirm;
      src_r        <= src_n;
      dst_r        <= dst_n;
      car_floor    <= car_n;
      floor_leds   <= leds_n;
      moving_up    <= up_n;
      moving_down  <= down_n;
      door_open    <= (state_n == DOOR_PICKUP) || (state_n == DOOR_DEST);
      busy         <= (state_n != IDLE);
      done         <= done_n;
      req_dropped  <= drop_n;
`ifdef ELEVATOR_REQUEST_QUEUE_EN
      pend_valid_r <= pend_valid_n;
      pend_src_r   <= pend_src_n;
      pend_dst_r   <= pend_dst_n;
`endif
    end
  end

endmodule

// File: tb/tb_elevator_move_controller.sv
// Bench for elevator_move_controller: directed steps plus random requests,
// checked every cycle against a trip-timeline reference model.
module tb_elevator_move_controller;

  localparam int NF  = 9;
  localparam int TPF = 4;
  localparam int DT  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  current = 5'd0;
  logic [4:0]  destination = 5'd0;
  logic        input_confirm = 1'b0;
  logic [4:0]  car_floor;
  logic [8:0]  floor_leds;
  logic        moving_up, moving_down, door_open, busy, done, req_dropped;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a trip is a timeline indexed by cycles since it began.
  int m_car = 1;
  bit m_active = 1'b0;
  int m_t, m_from, m_src, m_dst, m_len;
  bit m_done = 1'b0, m_drop = 1'b0, m_conf_prev = 1'b0;
  bit m_pend = 1'b0;
  int m_psrc, m_pdst;

  elevator_move_controller #(.NUM_FLOORS(NF), .TICKS_PER_FLOOR(TPF), .DOOR_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .current(current), .destination(destination),
    .input_confirm(input_confirm), .car_floor(car_floor), .floor_leds(floor_leds),
    .moving_up(moving_up), .moving_down(moving_down), .door_open(door_open),
    .busy(busy), .done(done), .req_dropped(req_dropped)
  );

  always #5 clk = ~clk;

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sgn_i(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  task automatic model_launch(input int s, input int d);
    m_active = 1'b1;
    m_t      = 0;
    m_from   = m_car;
    m_src    = s;
    m_dst    = d;
    m_len    = abs_i(s - m_car) * TPF + DT + ((s == d) ? 0 : abs_i(d - s) * TPF + DT);
  endtask

  task automatic model_reset();
    m_car = 1; m_active = 1'b0; m_done = 1'b0; m_drop = 1'b0;
    m_conf_prev = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_edge();
    bit ev, valid, busy_eff, pre_done, pre_pend;
    ev          = input_confirm && !m_conf_prev;
    m_conf_prev = input_confirm;
    valid       = (current >= 1) && (current <= NF) && (destination >= 1) && (destination <= NF);
    busy_eff    = m_active || m_done || m_pend;
    pre_done    = m_done;
    pre_pend    = m_pend;
    m_done      = 1'b0;
    m_drop      = 1'b0;
    if (m_active) begin
      m_t++;
      if (m_t == m_len) begin
        m_active = 1'b0;
        m_car    = m_dst;
        m_done   = 1'b1;
      end
    end else if (pre_pend) begin
      m_pend = 1'b0;
      model_launch(m_psrc, m_pdst);
    end else if (ev && valid && !pre_done) begin
      model_launch(int'(current), int'(destination));
    end
    if (ev && !valid) begin
      m_drop = 1'b1;
    end else if (ev && busy_eff) begin
`ifdef ELEVATOR_REQUEST_QUEUE_EN
      if (!pre_pend) begin
        m_pend = 1'b1; m_psrc = int'(current); m_pdst = int'(destination);
      end else begin
        m_drop = 1'b1;
      end
`else
      m_drop = 1'b1;
`endif
    end
  endtask

  // Layout: [19:15] car, [14:6] leds, [5] up, [4] down, [3] door, [2] busy, [1] done, [0] dropped.
  function automatic logic [19:0] exp_vec();
    int car, p1, p2;
    bit up, dn, door;
    logic [8:0] leds;
    car = m_car; up = 1'b0; dn = 1'b0; door = 1'b0;
    if (m_active) begin
      p1 = abs_i(m_src - m_from) * TPF;
      p2 = abs_i(m_dst - m_src) * TPF;
      if (m_t < p1) begin
        car = m_from + sgn_i(m_src - m_from) * (m_t / TPF);
        up = (m_src > m_from); dn = (m_src < m_from);
      end else if (m_t < p1 + DT) begin
        car = m_src; door = 1'b1;
      end else if (m_t < p1 + DT + p2) begin
        car = m_src + sgn_i(m_dst - m_src) * ((m_t - p1 - DT) / TPF);
        up = (m_dst > m_src); dn = (m_dst < m_src);
      end else begin
        car = m_dst; door = 1'b1;
      end
    end
    leds = 9'd1 << (car - 1);
    return {5'(car), leds, up, dn, door, m_active, m_done, m_drop};
  endfunction

  task automatic check_all(input string tag);
    logic [19:0] obs, expv;
    obs  = {car_floor, floor_leds, moving_up, moving_down, door_open, busy, done, req_dropped};
    expv = exp_vec();
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, expv);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic request(input logic [4:0] s, input logic [4:0] d);
    current = s; destination = d; input_confirm = 1'b1;
  endtask

  initial begin
    logic [19:0] ev;
    bool_found: begin end
    #12;
    check_all("reset");
    reset = 1'b0;

    // Trip 3 -> 5 from floor 1
    request(5'd3, 5'd5);
    for (int k = 1; k <= 24; k++) begin
      step("trip35");
      if (k == 1) input_confirm = 1'b0;
      if (k == 4)  check_val("t1_car_c4", car_floor, 1);
      if (k == 5)  check_val("t1_car_c5", car_floor, 2);
      if (k == 9)  check_val("t1_door_c9", {car_floor, door_open}, {5'd3, 1'b1});
      if (k == 12) check_val("t1_door_c12", door_open, 0);
      if (k == 16) check_val("t1_car_c16", car_floor, 4);
      if (k == 20) check_val("t1_door_c20", {car_floor, door_open}, {5'd5, 1'b1});
      if (k == 23) check_val("t1_done_c23", {done, busy}, 2'b10);
    end

    // Trip 5 -> 2 starting with the door open
    request(5'd5, 5'd2);
    for (int k = 1; k <= 20; k++) begin
      step("trip52");
      if (k == 1)  input_confirm = 1'b0;
      if (k == 1)  check_val("t2_door_c1", door_open, 1);
      if (k == 5)  check_val("t2_down_c5", {moving_up, moving_down}, 2'b01);
      if (k == 16) check_val("t2_car_c16", car_floor, 2);
      if (k == 19) check_val("t2_done_c19", done, 1);
    end

    // Invalid requests
    request(5'd0, 5'd3);
    step("inv_src0");
    check_val("t3_drop_src0", {req_dropped, busy}, 2'b10);
    input_confirm = 1'b0;
    step("inv_idle");
    request(5'd4, 5'd10);
    step("inv_dst10");
    check_val("t3_drop_dst10", {req_dropped, busy, car_floor}, {1'b1, 1'b0, 5'd2});
    input_confirm = 1'b0;
    step("inv_idle2");

    // Second and third edges while busy
    request(5'd2, 5'd6);
    step("busy_first");
    input_confirm = 1'b0;
    for (int k = 0; k < 5; k++) step("busy_run");
    request(5'd7, 5'd1);
    step("busy_second");
`ifdef ELEVATOR_REQUEST_QUEUE_EN
    check_val("t4_second_queued", req_dropped, 0);
`else
    check_val("t4_second_dropped", req_dropped, 1);
`endif
    input_confirm = 1'b0;
    step("busy_gap");
    request(5'd3, 5'd3);
    step("busy_third");
    check_val("t4_third_dropped", req_dropped, 1);
    input_confirm = 1'b0;
    for (int k = 0; k < 80; k++) step("busy_drain");

    // Reset while travelling between floors 3 and 4
    request(5'd3, 5'd6);
    step("rst_launch");
    input_confirm = 1'b0;
    ev = exp_vec();
    for (int g = 0; g < 200 && !(ev[19:15] == 5'd3 && ev[5]); g++) begin
      step("rst_approach");
      ev = exp_vec();
    end
    check_val("t5_reached_3_up", {ev[19:15], ev[5]}, {5'd3, 1'b1});
    step("rst_between");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    #2;
    reset = 1'b0;
    request(5'd2, 5'd3);
    for (int k = 1; k <= 20; k++) begin
      step("post_reset");
      if (k == 1) input_confirm = 1'b0;
      if (k == 4) check_val("t5_from_floor1", car_floor, 1);
    end

    // Held confirm gives exactly one request
    request(5'd5, 5'd5);
    for (int k = 0; k < 20; k++) step("held_high");
    input_confirm = 1'b0;
    for (int k = 0; k < 30; k++) step("held_release");

    // Random requests
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        current = 5'($urandom_range(0, 10));
        destination = 5'($urandom_range(0, 10));
      end else begin
        current = 5'($urandom_range(1, NF));
        destination = 5'($urandom_range(1, NF));
      end
      input_confirm = 1'b1;
      for (int h = $urandom_range(1, 3); h > 0; h--) step("rand_hold");
      input_confirm = 1'b0;
      for (int g = $urandom_range(0, 60); g > 0; g--) step("rand_gap");
    end
    for (int k = 0; k < 150; k++) step("drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
